// File: rtl/pipelined_adder_pkg.sv
// Shared constants for the segmented pipelined adder.
package pipelined_adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;

  // Encoding of the sub input.
  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } sub_mode_e;

  // One pipeline stage per SEG-bit slice of the operands.
  function automatic int num_stages(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit ripple adder; exposes the carry into its top bit so
// the final stage can form signed overflow.
module adder_segment
  import pipelined_adder_pkg::*;
#(
  parameter int SEG = DEF_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb
);

  logic [SEG:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout  = c[SEG];
  assign c_msb = c[SEG-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// Segmented add/subtract pipeline: stage k sums operand slice k using the
// carry registered by stage k-1. Unsummed upper slices ride in shrinking skew
// registers, finished low slices grow toward the output. Whole pipe stalls
// together on output backpressure. WIDTH must be a positive multiple of SEG.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow
);

  localparam int STAGES = num_stages(WIDTH, SEG);

  logic             adv;
  logic             sub_en;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [STAGES:1]  vld_pipe;

  // Subtract is A + ~B + ~borrow_in, so one adder serves both modes.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign sub_en   = (sub_mode_e'(sub) == SUB);
  assign b_eff    = sub_en ? ~b : b;
  assign cin_eff  = sub_en ? ~carry_in : carry_in;

  // Valid shift register, one bit per stage; bubbles travel as zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
    end else if (adv) begin
      vld_pipe[1] <= in_valid;
      for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  assign out_valid = vld_pipe[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO  = k * SEG;
    localparam int REM = WIDTH - LO;   // operand bits still unsummed on entry

    logic [REM-1:0]    a_up;
    logic [REM-1:0]    b_up;
    logic              ci;
    logic              sub_in;
    logic [SEG-1:0]    seg_sum;
    logic              co;
    logic              c_msb;
    logic [LO+SEG-1:0] sum_d;
    logic [LO+SEG-1:0] sum_q;

    if (k == 0) begin : g_src
      assign a_up   = a;
      assign b_up   = b_eff;
      assign ci     = cin_eff;
      assign sub_in = sub_en;
      assign sum_d  = seg_sum;
    end else begin : g_src
      assign a_up   = g_stg[k-1].g_skew.a_hi;
      assign b_up   = g_stg[k-1].g_skew.b_hi;
      assign ci     = g_stg[k-1].g_skew.cy_q;
      assign sub_in = g_stg[k-1].g_skew.sub_q;
      assign sum_d  = {seg_sum, g_stg[k-1].sum_q};
    end

    adder_segment #(.SEG(SEG)) u_seg (
      .a     (a_up[SEG-1:0]),
      .b     (b_up[SEG-1:0]),
      .cin   (ci),
      .sum   (seg_sum),
      .cout  (co),
      .c_msb (c_msb)
    );

    // Finished low-order sum slices move forward with their beat.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)    sum_q <= '0;
      else if (adv) sum_q <= sum_d;
    end

    if (k < STAGES-1) begin : g_skew
      logic [REM-SEG-1:0] a_hi;
      logic [REM-SEG-1:0] b_hi;
      logic               cy_q;
      logic               sub_q;
      logic               unused_msb;

      // Carry into a mid-word bit has no meaning for the result.
      assign unused_msb = c_msb;

      // Carry plus the still-unsummed upper slices skew down one stage.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_hi  <= '0;
          b_hi  <= '0;
          cy_q  <= 1'b0;
          sub_q <= 1'b0;
        end else if (adv) begin
          a_hi  <= a_up[REM-1:SEG];
          b_hi  <= b_up[REM-1:SEG];
          cy_q  <= co;
          sub_q <= sub_in;
        end
      end
    end else begin : g_last
      logic co_q;
      logic ovf_q;

      // Final flags: borrow is the inverted raw carry in subtract mode.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          co_q  <= 1'b0;
          ovf_q <= 1'b0;
        end else if (adv) begin
          co_q  <= co ^ sub_in;
          ovf_q <= co ^ c_msb;
        end
      end
    end
  end

  assign out       = g_stg[STAGES-1].sum_q;
  assign carry_out = g_stg[STAGES-1].g_last.co_q;
  assign overflow  = g_stg[STAGES-1].g_last.ovf_q;

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a positive multiple of SEG.
REQ-002 Parameter SEG, default 4, bits added per pipeline stage; STAGES = WIDTH/SEG.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 carry_in  input  1  carry in (add) / borrow in (subtract).
REQ-010 sub  input  1  0 = A+B+carry_in, 1 = A-B-carry_in.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out  output  WIDTH  result.
REQ-014 carry_out  output  1  carry out (add) / borrow out (subtract).
REQ-015 overflow  output  1  two's-complement signed overflow of the operation.

Function
REQ-016 Beat accepted iff in_valid && in_ready; result delivered iff out_valid && out_ready.
REQ-017 Pipeline SHALL advance when adv = !out_valid || out_ready; in_ready SHALL equal adv (combinational, no dependence on in_valid).
REQ-018 When adv = 0 every stage register SHALL hold; out, carry_out, overflow SHALL remain stable while out_valid && !out_ready.
REQ-019 Stage k (0..STAGES-1) SHALL add bits [k*SEG +: SEG] of A and effective B plus the carry registered by stage k-1; stage 0 uses the effective carry in.
REQ-020 Effective B = sub ? ~b : b; effective carry in = sub ? ~carry_in : carry_in; both SHALL be captured at acceptance with the operands.
REQ-021 Upper operand segments SHALL travel in skew registers alongside the carry so each segment meets its carry in the correct stage; completed lower sum segments SHALL be carried forward to the output.
REQ-022 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when adv stays 1; throughput one beat per cycle.
REQ-023 Each stage SHALL carry a valid bit; bubbles (in_valid = 0 while adv = 1) SHALL propagate as invalid stages, and out_valid SHALL be the last stage valid bit.
REQ-024 out SHALL equal (A + effB + effCin) mod 2^WIDTH.
REQ-025 carry_out SHALL be the final raw carry when sub = 0 and its inverse (borrow) when sub = 1.
REQ-026 overflow SHALL be the XOR of the carries into and out of bit WIDTH-1.
REQ-027 Result order SHALL equal acceptance order; no beat dropped or duplicated under any out_ready pattern.
REQ-028 STAGES = 1 SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-029 On reset all stage valid bits and out_valid SHALL clear to 0 immediately; out, carry_out, overflow SHALL reset to 0.
REQ-030 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-031 Reset mid-operation SHALL discard all in-flight beats; none SHALL emerge after deassertion.

Structure
REQ-032 A shared constants file SHALL hold default WIDTH and SEG and the sub-mode encoding (ADD = 0, SUB = 1).
REQ-033 One sub-module, adder_segment, SHALL implement a combinational SEG-bit ripple add (a, b, cin -> sum, cout, carry into MSB), built from the existing full_adder cell and instantiated once per stage.
REQ-034 All registers SHALL live in pipelined_adder; adder_segment SHALL contain no state.

Verification (WIDTH = 16, SEG = 4)
REQ-035 Add 0x1234 + 0x0FFF, carry_in 0 -> out 0x2233, carry_out 0, overflow 0, out_valid exactly 4 cycles after acceptance.
REQ-036 Add 0xFFFF + 0x0001, carry_in 0 -> out 0x0000, carry_out 1 (carry ripples through all 4 stages); 0x7FFF + 0x0001 -> out 0x8000, overflow 1.
REQ-037 Sub 0x0005 - 0x0007, carry_in 0 -> out 0xFFFE, carry_out (borrow) 1, overflow 0; sub 0x8000 - 0x0001 -> out 0x7FFF, overflow 1.
REQ-038 Back-to-back 8 random beats with out_ready = 1 -> 8 correct results on 8 consecutive cycles, in order.
REQ-039 Hold out_ready = 0 for 5 cycles with full pipeline -> in_ready 0, out stable, no loss; release -> remaining beats drain in order.
REQ-040 Assert reset with 3 beats in flight -> out_valid 0 at once, in_ready 1; no stale result appears in 10 cycles after release.
